regfile_8x16_sb: RTL and testbench
==================================

Name: regfile_8x16_sb

Overview:
- Eight-entry, 16-bit register file with two read ports, one write port, write-to-read bypass and a per-register busy scoreboard.
- Sits directly upstream of the 8:1 16-bit read-select muxes in decode. Each read port presents the eight register outputs, selected by a 3-bit register index, to one select tree.
- The scoreboard tracks registers with an outstanding pipelined write, so decode can stall on RAW hazards.

Parameters:
- WIDTH, 16, data width of each register and of the read/write data ports.
- BYPASS, 1, 1 = same-cycle write data forwarded to matching read ports; 0 = reads return only the stored value.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- rst_n  input  1  synchronous active-low reset, sampled on posedge clk.
- read1_reg  input  3  read port 1 register index.
- read2_reg  input  3  read port 2 register index.
- read1_data  output  WIDTH  read port 1 data (combinational).
- read2_data  output  WIDTH  read port 2 data (combinational).
- read1_busy  output  1  read port 1 register has a pending write not resolved this cycle.
- read2_busy  output  1  read port 2 register has a pending write not resolved this cycle.
- write_en  input  1  writeback strobe.
- write_reg  input  3  writeback register index.
- write_data  input  WIDTH  writeback data.
- rsv_en  input  1  issue-time reservation strobe (marks destination busy).
- rsv_reg  input  3  register index being reserved.
- busy_vec  output  8  current scoreboard bits, bit i = register i.
- err  output  1  sticky protocol-error flag.

Behaviour:
- Reset: rst_n low at a posedge clears all eight registers to 0, busy_vec to 8'h00 and err to 0. After reset, read1_data = read2_data = 0 and read1_busy = read2_busy = 0.
- Reset has priority over write_en and rsv_en in the same cycle; both are ignored.
- Reset mid-operation discards pending reservations. No write completes in the reset cycle.
- Write: write_en = 1 at posedge stores write_data into reg[write_reg]. Exactly one register changes per cycle. All eight registers are writable, including index 0.
- Read: readN_data = reg[readN_reg], combinational, zero cycles of latency.
- Both ports may read the same register simultaneously; both return the same value.
- Bypass (BYPASS = 1): if write_en = 1 and write_reg == readN_reg, then readN_data = write_data in that same cycle, for each port independently.
- BYPASS = 0: readN_data is the old stored value until the cycle after the write.
- Scoreboard update at each posedge:
  - rsv_en sets busy[rsv_reg].
  - write_en clears busy[write_reg].
  - Same index set and cleared in one cycle: set wins. The old write completes and the new reservation is pending, giving busy = 1 after the edge.
  - Different indices: both updates apply.
- readN_busy = busy[readN_reg] AND NOT (BYPASS AND write_en AND write_reg == readN_reg). A resolving writeback un-stalls decode in the same cycle when bypass is enabled.
- busy_vec is the registered busy[7:0]. It does not reflect the same-cycle bypass.
- err is set at a posedge, and stays set until reset, on either condition:
  - rsv_en to a register already busy that is not being cleared by write_en that cycle (double reservation).
  - write_en to a register whose busy bit is 0 (unreserved writeback).
- The data write in the unreserved-writeback case still occurs. An erroneous reservation still leaves busy = 1.
- No combinational path from any input to err or busy_vec.

Test Plan:
- Reset with rst_n = 0 for 2 cycles while driving write_en = 1, write_reg = 3, write_data = 16'hBEEF, rsv_en = 1 -> after release: all reads 0, busy_vec = 0, err = 0, and reg3 still reads 0.
- rsv_en reg5, then write_en reg5 = 16'h1234 two cycles later, read1_reg = 5 -> read1_busy = 1 during the wait. With BYPASS = 1, read1_data = 16'h1234 and read1_busy = 0 in the write cycle. Next cycle busy_vec[5] = 0 and data stays 16'h1234.
- Same-cycle rsv_en reg2 and write_en reg2 = 16'h00AA (reg2 previously reserved) -> reg2 = 16'h00AA, busy_vec[2] = 1, err = 0.
- Write all 8 registers with 16'h1000+i, then sweep read1_reg 0..7 and read2_reg 7..0 -> each port returns 16'h1000+index, including both ports on the same index.
- rsv_en reg4 twice with no intervening write -> err = 1 after the second edge; it stays set through subsequent legal traffic until rst_n = 0.
- BYPASS = 0 build: write reg6 = 16'hCAFE while read2_reg = 6 -> read2_data shows the old value in that cycle and 16'hCAFE in the next. write_en reg1 with busy[1] = 0 -> err = 1 and reg1 is updated.

Source files
------------

// File: rtl/regfile_8x16_sb.sv
// regfile_8x16_sb: 8 x WIDTH register file with two combinational read ports,
// one write port, optional write-to-read bypass and a per-register busy
// scoreboard with a sticky protocol-error flag.
module regfile_8x16_sb #(
  parameter int unsigned WIDTH  = 16,
  parameter bit          BYPASS = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [2:0]       read1_reg,
  input  logic [2:0]       read2_reg,
  output logic [WIDTH-1:0] read1_data,
  output logic [WIDTH-1:0] read2_data,
  output logic             read1_busy,
  output logic             read2_busy,
  input  logic             write_en,
  input  logic [2:0]       write_reg,
  input  logic [WIDTH-1:0] write_data,
  input  logic             rsv_en,
  input  logic [2:0]       rsv_reg,
  output logic [7:0]       busy_vec,
  output logic             err
);

  localparam int unsigned NREG = 8;

  logic [WIDTH-1:0] regs_q [NREG];
  logic [WIDTH-1:0] regs_d [NREG];
  logic [NREG-1:0]  busy_q, busy_d;
  logic             err_q, err_d;

  logic wr_hit1, wr_hit2;
  logic dbl_rsv, unrsv_wr;

  // Next-state: data write, scoreboard clear/set (set wins), sticky error.
  always_comb begin
    regs_d   = regs_q;
    busy_d   = busy_q;
    err_d    = err_q;
    dbl_rsv  = rsv_en && busy_q[rsv_reg] && !(write_en && (write_reg == rsv_reg));
    unrsv_wr = write_en && !busy_q[write_reg];
    if (write_en) begin
      regs_d[write_reg] = write_data;
      busy_d[write_reg] = 1'b0;
    end
    if (rsv_en) begin
      busy_d[rsv_reg] = 1'b1;
    end
    if (dbl_rsv || unrsv_wr) begin
      err_d = 1'b1;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(NREG); i++) begin
        regs_q[i] <= '0;
      end
      busy_q <= '0;
      err_q  <= 1'b0;
    end else begin
      regs_q <= regs_d;
      busy_q <= busy_d;
      err_q  <= err_d;
    end
  end

  // Read ports: stored value, overridden by same-cycle write data when bypassing.
  always_comb begin
    wr_hit1    = BYPASS && write_en && (write_reg == read1_reg);
    wr_hit2    = BYPASS && write_en && (write_reg == read2_reg);
    read1_data = wr_hit1 ? write_data : regs_q[read1_reg];
    read2_data = wr_hit2 ? write_data : regs_q[read2_reg];
    read1_busy = busy_q[read1_reg] && !wr_hit1;
    read2_busy = busy_q[read2_reg] && !wr_hit2;
  end

  assign busy_vec = busy_q;
  assign err      = err_q;

endmodule

// File: tb/tb_regfile_8x16_sb.sv
// Scoreboard bench for regfile_8x16_sb: one bypassing and one non-bypassing
// instance share stimulus; a driver pushes expected outputs from an abstract
// model and a negedge monitor pops and compares.
module tb_regfile_8x16_sb;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  read1_reg, read2_reg, write_reg, rsv_reg;
  logic        write_en, rsv_en;
  logic [15:0] write_data;

  logic [15:0] b_r1d, b_r2d, n_r1d, n_r2d;
  logic        b_r1b, b_r2b, n_r1b, n_r2b;
  logic [7:0]  b_bv, n_bv;
  logic        b_err, n_err;

  always #5 clk = ~clk;

  regfile_8x16_sb #(.WIDTH(16), .BYPASS(1'b1)) dut (
    .clk(clk), .rst_n(rst_n),
    .read1_reg(read1_reg), .read2_reg(read2_reg),
    .read1_data(b_r1d), .read2_data(b_r2d),
    .read1_busy(b_r1b), .read2_busy(b_r2b),
    .write_en(write_en), .write_reg(write_reg), .write_data(write_data),
    .rsv_en(rsv_en), .rsv_reg(rsv_reg),
    .busy_vec(b_bv), .err(b_err)
  );

  regfile_8x16_sb #(.WIDTH(16), .BYPASS(1'b0)) dut_nb (
    .clk(clk), .rst_n(rst_n),
    .read1_reg(read1_reg), .read2_reg(read2_reg),
    .read1_data(n_r1d), .read2_data(n_r2d),
    .read1_busy(n_r1b), .read2_busy(n_r2b),
    .write_en(write_en), .write_reg(write_reg), .write_data(write_data),
    .rsv_en(rsv_en), .rsv_reg(rsv_reg),
    .busy_vec(n_bv), .err(n_err)
  );

  typedef struct {
    logic [15:0] r1d_b, r2d_b, r1d_n, r2d_n;
    logic        r1b_b, r2b_b, r1b_n, r2b_n;
    logic [7:0]  bv;
    logic        err;
  } exp_t;

  exp_t exp_q[$];

  // Reference model: register contents, busy flags, sticky error.
  logic [15:0] m_mem [8];
  logic        m_busy [8];
  logic        m_err;
  bit          m_valid = 1'b0;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: outputs are stable mid-cycle; compare against the oldest expectation.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("byp_read1_data", b_r1d, e.r1d_b);
      chk("byp_read2_data", b_r2d, e.r2d_b);
      chk("byp_read1_busy", 16'(b_r1b), 16'(e.r1b_b));
      chk("byp_read2_busy", 16'(b_r2b), 16'(e.r2b_b));
      chk("byp_busy_vec",   16'(b_bv),  16'(e.bv));
      chk("byp_err",        16'(b_err), 16'(e.err));
      chk("nb_read1_data",  n_r1d, e.r1d_n);
      chk("nb_read2_data",  n_r2d, e.r2d_n);
      chk("nb_read1_busy",  16'(n_r1b), 16'(e.r1b_n));
      chk("nb_read2_busy",  16'(n_r2b), 16'(e.r2b_n));
      chk("nb_busy_vec",    16'(n_bv),  16'(e.bv));
      chk("nb_err",         16'(n_err), 16'(e.err));
    end
  end

  // One clock of stimulus: drive, push expectations from the model, advance model.
  task automatic step(input logic rst, input logic we, input logic [2:0] wr,
                      input logic [15:0] wd, input logic rs, input logic [2:0] rr,
                      input logic [2:0] r1, input logic [2:0] r2);
    exp_t e;
    logic hit1, hit2;
    rst_n = rst; write_en = we; write_reg = wr; write_data = wd;
    rsv_en = rs; rsv_reg = rr; read1_reg = r1; read2_reg = r2;
    if (m_valid) begin
      hit1 = we && (wr == r1);
      hit2 = we && (wr == r2);
      e.r1d_n = m_mem[r1];
      e.r2d_n = m_mem[r2];
      e.r1d_b = hit1 ? wd : m_mem[r1];
      e.r2d_b = hit2 ? wd : m_mem[r2];
      e.r1b_n = m_busy[r1];
      e.r2b_n = m_busy[r2];
      e.r1b_b = m_busy[r1] && !hit1;
      e.r2b_b = m_busy[r2] && !hit2;
      for (int i = 0; i < 8; i++) e.bv[i] = m_busy[i];
      e.err = m_err;
      exp_q.push_back(e);
    end
    if (!rst) begin
      for (int i = 0; i < 8; i++) begin
        m_mem[i]  = 16'h0000;
        m_busy[i] = 1'b0;
      end
      m_err   = 1'b0;
      m_valid = 1'b1;
    end else begin
      if (rs && m_busy[rr] && !(we && wr == rr)) m_err = 1'b1;
      if (we && !m_busy[wr]) m_err = 1'b1;
      if (we) begin
        m_mem[wr]  = wd;
        m_busy[wr] = 1'b0;
      end
      if (rs) m_busy[rr] = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic [2:0] r1, input logic [2:0] r2);
    step(1'b1, 1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, r1, r2);
  endtask

  // Mostly-legal random traffic: reserve free registers, write back busy ones.
  task automatic rand_batch(input int n);
    logic        we, rs;
    logic [2:0]  wr, rr;
    step(1'b0, 1'($urandom_range(0, 1)), 3'($urandom), 16'($urandom),
         1'($urandom_range(0, 1)), 3'($urandom), 3'($urandom), 3'($urandom));
    for (int k = 0; k < n; k++) begin
      rs = ($urandom_range(0, 99) < 50);
      rr = 3'($urandom);
      if ($urandom_range(0, 99) < 95)
        for (int t = 0; t < 8 && m_busy[rr]; t++) rr = 3'($urandom);
      we = ($urandom_range(0, 99) < 50);
      wr = 3'($urandom);
      if ($urandom_range(0, 99) < 95)
        for (int t = 0; t < 8 && !m_busy[wr]; t++) wr = 3'($urandom);
      step(1'b1, we, wr, 16'($urandom), rs, rr,
           ($urandom_range(0, 3) == 0) ? wr : 3'($urandom),
           ($urandom_range(0, 3) == 0) ? wr : 3'($urandom));
    end
  endtask

  initial begin
    // Reset held two cycles while write/reserve are asserted.
    step(1'b0, 1'b1, 3'd3, 16'hBEEF, 1'b1, 3'd3, 3'd3, 3'd3);
    step(1'b0, 1'b1, 3'd3, 16'hBEEF, 1'b1, 3'd3, 3'd3, 3'd3);
    idle(3'd3, 3'd0);

    // Reserve reg5, wait, resolve with bypass, then settled read.
    step(1'b1, 1'b0, 3'd0, 16'h0000, 1'b1, 3'd5, 3'd5, 3'd0);
    idle(3'd5, 3'd5);
    idle(3'd5, 3'd1);
    step(1'b1, 1'b1, 3'd5, 16'h1234, 1'b0, 3'd0, 3'd5, 3'd5);
    idle(3'd5, 3'd5);

    // Same-cycle set and clear on reg2 while already reserved.
    step(1'b1, 1'b0, 3'd0, 16'h0000, 1'b1, 3'd2, 3'd2, 3'd2);
    step(1'b1, 1'b1, 3'd2, 16'h00AA, 1'b1, 3'd2, 3'd2, 3'd5);
    idle(3'd2, 3'd2);

    // Fresh state, reserve and write all eight, then cross sweep.
    step(1'b0, 1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 3'd0, 3'd0);
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 3'd0, 16'h0, 1'b1, 3'(i), 3'(i), 3'(7 - i));
    for (int i = 0; i < 8; i++)
      step(1'b1, 1'b1, 3'(i), 16'h1000 + 16'(i), 1'b0, 3'd0, 3'(i), 3'(7 - i));
    for (int i = 0; i < 8; i++) idle(3'(i), 3'(7 - i));

    // Double reservation on reg4: err sticks through legal traffic until reset.
    step(1'b1, 1'b0, 3'd0, 16'h0, 1'b1, 3'd4, 3'd4, 3'd4);
    step(1'b1, 1'b0, 3'd0, 16'h0, 1'b1, 3'd4, 3'd4, 3'd4);
    step(1'b1, 1'b1, 3'd4, 16'h4444, 1'b0, 3'd0, 3'd4, 3'd0);
    idle(3'd4, 3'd0);
    step(1'b0, 1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 3'd4, 3'd0);
    idle(3'd4, 3'd0);

    // Write reg6 while reading it (bypass vs. stored), then unreserved write to reg1.
    step(1'b1, 1'b0, 3'd0, 16'h0, 1'b1, 3'd6, 3'd0, 3'd6);
    step(1'b1, 1'b1, 3'd6, 16'hCAFE, 1'b0, 3'd0, 3'd6, 3'd6);
    idle(3'd0, 3'd6);
    step(1'b1, 1'b1, 3'd1, 16'h5A5A, 1'b0, 3'd0, 3'd1, 3'd1);
    idle(3'd1, 3'd1);

    // Randomized batches, each opening with a reset.
    for (int b = 0; b < 6; b++) rand_batch(150);
    idle(3'd0, 3'd0);

    // Drain scoreboard within a bounded number of cycles.
    for (int w = 0; w < 5 && exp_q.size() > 0; w++) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
